// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle between the data-memory arbiter, its two
// requesters (core MEM stage C, loader/debug X) and the memory port M.
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          C_Req;
   logic          C_WE;
   logic [AW-1:0] C_Addr;
   logic [DW-1:0] C_WData;
   logic [DW-1:0] C_RData;
   logic          C_Stall;

   logic          X_Req;
   logic          X_WE;
   logic [AW-1:0] X_Addr;
   logic [DW-1:0] X_WData;
   logic          X_Lock;
   logic          X_Gnt;
   logic          X_RValid;
   logic [DW-1:0] X_RData;

   logic          M_WE;
   logic [AW-1:0] M_Addr;
   logic [DW-1:0] M_WData;
   logic [DW-1:0] M_RData;

   modport slave (
      input  C_Req, C_WE, C_Addr, C_WData,
      output C_RData, C_Stall,
      input  X_Req, X_WE, X_Addr, X_WData, X_Lock,
      output X_Gnt, X_RValid, X_RData,
      output M_WE, M_Addr, M_WData,
      input  M_RData
   );

   modport master (
      output C_Req, C_WE, C_Addr, C_WData,
      input  C_RData, C_Stall,
      output X_Req, X_WE, X_Addr, X_WData, X_Lock,
      input  X_Gnt, X_RValid, X_RData,
      input  M_WE, M_Addr, M_WData,
      output M_RData
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the MEM stage (C,
// default priority) and an external master (X, starvation guard + burst lock).
// Ports: CLK, Reset (async active-low), bus (C_*, X_*, M_* via slave modport).
module dmem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4,
   parameter int LOCK_MAX = 8
) (
   input logic            CLK,
   input logic            Reset,
   dmem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE,
      CPU,
      EXT,
      EXT_LOCK
   } owner_t;

   localparam logic [3:0] WaitMax = 4'(MAX_WAIT);
   localparam logic [7:0] LockMax = 8'(LOCK_MAX);

   owner_t        state;
   logic [3:0]    waitCnt;
   logic [7:0]    lockCnt;
   logic          rValid;
   logic [DW-1:0] rData;

   logic          lockHold;
   logic          xWin;
   logic          xGnt;
   logic          cGnt;
   logic [AW-1:0] addrMux;
   logic [DW-1:0] wdataMux;
   logic          weMux;

   // Lock rule first, then starvation guard / idle C, then C.
   // Reset gates both grants so nothing reaches memory in reset.
   always_comb begin
      lockHold = (state == EXT_LOCK) && bus.X_Req
               && (lockCnt < LockMax);
      xWin = lockHold
           || (bus.X_Req && (!bus.C_Req || waitCnt == WaitMax));
      xGnt = Reset && xWin;
      cGnt = Reset && !xWin && bus.C_Req;
   end

   always_comb begin
      addrMux  = bus.C_Addr;
      wdataMux = bus.C_WData;
      weMux    = 1'b0;
      if (xGnt) begin
         addrMux  = bus.X_Addr;
         wdataMux = bus.X_WData;
         weMux    = bus.X_WE;
      end else if (cGnt) begin
         weMux    = bus.C_WE;
      end
   end

   assign bus.M_WE     = weMux;
   assign bus.M_Addr   = addrMux;
   assign bus.M_WData  = wdataMux;
   assign bus.C_RData  = bus.M_RData;
   assign bus.C_Stall  = Reset && bus.C_Req && !cGnt;
   assign bus.X_Gnt    = xGnt;
   assign bus.X_RValid = rValid;
   assign bus.X_RData  = rData;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         waitCnt <= '0;
         lockCnt <= '0;
         rValid  <= 1'b0;
         rData   <= '0;
      end else begin
         rValid <= xGnt && !bus.X_WE;
         if (xGnt && !bus.X_WE)
            rData <= bus.M_RData;

         if (xGnt || !bus.X_Req)
            waitCnt <= '0;
         else if (waitCnt != WaitMax)
            waitCnt <= waitCnt + 4'd1;

         // A locked grant that did not come through the lock rule
         // (fresh entry or cap reached with C idle) restarts the count.
         unique case (1'b1)
            xGnt && bus.X_Lock: begin
               state   <= EXT_LOCK;
               lockCnt <= lockHold ? lockCnt + 8'd1 : 8'd1;
            end
            xGnt && !bus.X_Lock: begin
               state   <= EXT;
               lockCnt <= '0;
            end
            cGnt: begin
               state   <= CPU;
               lockCnt <= '0;
            end
            default: begin
               state   <= IDLE;
               lockCnt <= '0;
            end
         endcase
      end
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core's MEM stage (port C) and an external loader/debug master (port X).
- Port C has default priority.
- Port X has a starvation guard and a bounded burst lock.
- Port C is stalled when it loses arbitration, and the core's hazard logic freezes the pipeline on that stall.
- Memory reads are combinational; writes occur on the CLK edge.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 4, consecutive cycles X may be denied while C requests before X is forced through. Range 1..15.
- LOCK_MAX, 8, maximum consecutive locked X grants before lock is broken for one C grant. Range 2..255.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- C_Req  in  1  MEM stage has a load/store this cycle.
- C_WE  in  1  1 = store.
- C_Addr  in  AW  address.
- C_WData  in  DW  store data.
- C_RData  out  DW  load data (combinational from M_RData).
- C_Stall  out  1  C_Req && !C_Gnt.
- X_Req  in  1  external request; held until X_Gnt.
- X_WE  in  1  1 = write.
- X_Addr  in  AW  address.
- X_WData  in  DW  write data.
- X_Lock  in  1  keep ownership for following beats (burst).
- X_Gnt  out  1  X access performed this cycle.
- X_RValid  out  1  registered read-data valid.
- X_RData  out  DW  registered read data.
- M_WE  out  1  memory write enable.
- M_Addr  out  AW  memory address.
- M_WData  out  DW  memory write data.
- M_RData  in  DW  memory read data (combinational).

Behaviour:
- Owner state register, values IDLE, CPU, EXT, EXT_LOCK; it records the grant of the previous cycle.
- Counters:
  - wait_cnt (4 b, saturates at MAX_WAIT).
  - lock_cnt (8 b).
- Grant decision, combinational, evaluated in this order:
  1. state==EXT_LOCK && X_Req && lock_cnt<LOCK_MAX -> X.
  2. X_Req && (!C_Req || wait_cnt==MAX_WAIT) -> X.
  3. C_Req -> C.
  4. else none.
- At most one of C_Gnt/X_Gnt is high. C_Gnt is internal only.
- Mux:
  - Winner's WE/Addr/WData drive M_*.
  - With no grant: M_WE=0, M_Addr=C_Addr, M_WData=C_WData.
  - M_WE = granted WE only, never with no grant.
- Transitions:
  - X_Gnt && X_Lock -> EXT_LOCK.
  - X_Gnt && !X_Lock -> EXT.
  - C_Gnt -> CPU.
  - none -> IDLE.
  - EXT_LOCK exits immediately when X_Req or X_Lock drops; the next cycle then uses normal arbitration.
- wait_cnt:
  - +1 (saturating) when X_Req && !X_Gnt.
  - Cleared when X_Gnt or !X_Req.
- lock_cnt:
  - Set to 1 on entry to EXT_LOCK (a grant from a non-locked state with X_Lock).
  - +1 on each locked grant.
  - When lock_cnt==LOCK_MAX the lock rule is skipped for one cycle.
    - If C_Req, C wins that cycle, lock_cnt clears and state->CPU.
    - If !C_Req, X wins via rule 2 and lock_cnt restarts at 1.
- X read return:
  - X_RValid <= X_Gnt && !X_WE; X_RData <= M_RData when that read is granted.
  - Latency is exactly 1 cycle after X_Gnt.
  - X_RData holds its value otherwise.
  - X writes never raise X_RValid.
- C_Stall = C_Req && !C_Gnt. It is combinational, so the core holds C_* stable while stalled.
- Simultaneous first-cycle requests: C wins unless wait_cnt is saturated.
- Reset low (any time, including mid-burst):
  - state=IDLE, wait_cnt=0, lock_cnt=0, X_RValid=0, X_RData=0.
  - Combinational outputs forced: X_Gnt=0, M_WE=0, C_Stall=0.
  - A read in flight when reset asserts is dropped; no X_RValid follows.
- Worst-case C stall = LOCK_MAX cycles. Worst-case X wait under continuous C = MAX_WAIT cycles.

Test Plan:
1. Reset low with C_Req=1, C_WE=1: M_WE=0, C_Stall=0. Release reset, C_Addr=0x10, C_WData=0xDEADBEEF: write lands the same edge; read back at 0x10 on C_RData the next cycle = 0xDEADBEEF, C_Stall=0 throughout.
2. C_Req held high continuously, X_Req=1 read at 0x20 (mem=0x1234) from cycle 0: X denied cycles 0-3; X_Gnt=1 and C_Stall=1 in cycle 4; X_RValid=1, X_RData=0x1234 in cycle 5; C regains the grant in cycle 5.
3. Idle C, X burst with X_Lock=1, 3 writes to 0x40/0x44/0x48: X_Gnt on 3 consecutive cycles. C_Req raised mid-burst gets C_Stall=1 until X_Lock drops; state returns to IDLE/CPU.
4. X_Lock held with X_Req for 12 cycles, C_Req constant, LOCK_MAX=8: X granted 8 cycles, C granted cycle 9, then normal arbitration. C_Stall never exceeds 8 consecutive cycles.
5. Same-cycle C_Req and X_Req with wait_cnt=0: C wins, X_Gnt=0, wait_cnt=1. Drop X_Req: wait_cnt=0 next cycle.
6. Assert Reset low the cycle after an X read grant: X_RValid stays 0, lock/wait cleared. After release, first X_Req with idle C is granted the same cycle.
